// File: rtl/twiddle_seq_if.sv
// Control/status bundle between one SDF FFT stage datapath and its twiddle sequencer.
// Handshake: in_valid has no ready; a sample is accepted in every cycle in_valid=1 and the
// sequencer never back-pressures. sync_clr restarts the stage and consumes no sample.
interface twiddle_seq_if #(
  parameter int HALF = 32,
  parameter int W    = 24
);
  localparam int KW = $clog2(HALF);

  logic          in_valid;
  logic          sync_clr;
  logic [1:0]    state;
  logic [KW-1:0] k_out;
  logic [W-1:0]  w_r;
  logic [W-1:0]  w_i;
  logic          draining;
  logic          busy;

  modport master (
    output in_valid, sync_clr,
    input  state, k_out, w_r, w_i, draining, busy
  );

  modport slave (
    input  in_valid, sync_clr,
    output state, k_out, w_r, w_i, draining, busy
  );
endinterface

// File: rtl/twiddle_seq.sv
// Phase and twiddle sequencer for one radix-2 SDF FFT stage: FILL, then alternating
// BFLY/TWID half-frames; W = exp(-j*pi*k/HALF) during TWID, 1+j0 otherwise.
module twiddle_seq #(
  parameter int HALF     = 32,
  parameter int W        = 24,
  parameter int FRAC     = 8,
  parameter int DRAIN_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  twiddle_seq_if.slave bus
);
  localparam int KW = $clog2(HALF);
  localparam int PW = KW + 1;
  localparam int QH = HALF / 2;
  localparam int TW = FRAC + 2;
  localparam logic signed [W-1:0] UNITY = W'(2 ** FRAC);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BFLY = 2'd1,
    ST_TWID = 2'd2
  } stage_t;

  // round(2^FRAC * cos(pi*m/HALF)) for the first quarter wave, by Taylor series
  function automatic logic [TW-1:0] cos_q(input int m);
    real x;
    real term;
    real sum;
    x    = 3.14159265358979323846 * real'(m) / real'(HALF);
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n <= 16; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return TW'($rtoi(sum * real'(2 ** FRAC) + 0.5));
  endfunction

  logic [TW-1:0] c_tab [QH+1];

  for (genvar g = 0; g <= QH; g++) begin : g_tab
    localparam logic [TW-1:0] CV = cos_q(g);
    assign c_tab[g] = CV;
  end

  logic [PW-1:0]       phase_q, phase_d, phase_inc;
  logic                fill_q, fill_d;
  logic                drain_q, drain_d;
  logic [KW-1:0]       dcnt_q, dcnt_d;
  stage_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic signed [W-1:0] wr_q, wr_d, wi_q, wi_d;
  logic                busy_q, busy_d;
  logic                drain_go, adv;

  // A drain step happens on any idle cycle outside FILL; draining itself reads 1
  // only from the cycle after the first idle cycle.
  always_comb begin
    drain_go = 1'b0;
    if (DRAIN_EN != 0) begin
      drain_go = !bus.in_valid && (drain_q || (state_q != ST_FILL));
    end
  end

  assign adv = bus.in_valid | drain_go;

  always_comb begin
    phase_d   = phase_q;
    fill_d    = fill_q;
    drain_d   = drain_q;
    dcnt_d    = dcnt_q;
    phase_inc = phase_q + 1'b1;
    if (bus.sync_clr) begin
      phase_d = '0;
      fill_d  = 1'b1;
      drain_d = 1'b0;
      dcnt_d  = '0;
    end else if (adv) begin
      phase_d = phase_inc;
      if (phase_inc == PW'(HALF)) begin
        fill_d = 1'b0;
      end
      if (bus.in_valid) begin
        drain_d = 1'b0;
        dcnt_d  = '0;
      end else if (!drain_q) begin
        drain_d = 1'b1;
        dcnt_d  = KW'(1);
      end else if (dcnt_q == KW'(HALF - 1)) begin
        phase_d = '0;
        fill_d  = 1'b1;
        drain_d = 1'b0;
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = ST_FILL;
    k_d     = '0;
    if (!fill_d) begin
      if (phase_d[KW]) begin
        state_d = ST_BFLY;
      end else begin
        state_d = ST_TWID;
        k_d     = phase_d[KW-1:0];
      end
    end
  end

  logic [KW-1:0]        idx_r, idx_i;
  logic                 neg_r;
  logic signed [TW-1:0] tr, ti, t_r, t_i;

  // Quarter-wave folding: second quarter swaps the table roles and negates w_r.
  always_comb begin
    idx_r = '0;
    idx_i = '0;
    neg_r = 1'b0;
    if (k_d < KW'(QH)) begin
      idx_r = k_d;
      idx_i = KW'(QH) - k_d;
    end else begin
      idx_r = KW'(QH) - (k_d - KW'(QH));
      idx_i = k_d - KW'(QH);
      neg_r = 1'b1;
    end
    tr  = $signed(c_tab[idx_r]);
    ti  = $signed(c_tab[idx_i]);
    t_r = neg_r ? -tr : tr;
    t_i = -ti;
    wr_d = UNITY;
    wi_d = '0;
    if (state_d == ST_TWID) begin
      wr_d = W'(t_r);
      wi_d = W'(t_i);
    end
    busy_d = (state_d != ST_FILL) || drain_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      fill_q  <= 1'b1;
      drain_q <= 1'b0;
      dcnt_q  <= '0;
      state_q <= ST_FILL;
      k_q     <= '0;
      wr_q    <= UNITY;
      wi_q    <= '0;
      busy_q  <= 1'b0;
    end else if (bus.sync_clr || adv) begin
      phase_q <= phase_d;
      fill_q  <= fill_d;
      drain_q <= drain_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      k_q     <= k_d;
      wr_q    <= wr_d;
      wi_q    <= wi_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.k_out    = k_q;
  assign bus.w_r      = wr_q;
  assign bus.w_i      = wi_q;
  assign bus.draining = drain_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_twiddle_seq.sv
// Four twiddle_seq configurations share one stimulus stream; each is compared every
// cycle against a sample-count model using real trigonometry.
module tb_twiddle_seq;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic sync_clr = 1'b0;

  always #5 clk = ~clk;

  twiddle_seq_if #(.HALF(32),  .W(24)) if_a ();
  twiddle_seq_if #(.HALF(32),  .W(24)) if_b ();
  twiddle_seq_if #(.HALF(4),   .W(24)) if_c ();
  twiddle_seq_if #(.HALF(256), .W(16)) if_d ();

  assign if_a.in_valid = in_valid;
  assign if_a.sync_clr = sync_clr;
  assign if_b.in_valid = in_valid;
  assign if_b.sync_clr = sync_clr;
  assign if_c.in_valid = in_valid;
  assign if_c.sync_clr = sync_clr;
  assign if_d.in_valid = in_valid;
  assign if_d.sync_clr = sync_clr;

  twiddle_seq #(.HALF(32),  .W(24), .FRAC(8),  .DRAIN_EN(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  twiddle_seq #(.HALF(32),  .W(24), .FRAC(8),  .DRAIN_EN(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  twiddle_seq #(.HALF(4),   .W(24), .FRAC(8),  .DRAIN_EN(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  twiddle_seq #(.HALF(256), .W(16), .FRAC(14), .DRAIN_EN(1)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  int    p_half [4] = '{32, 32, 4, 256};
  int    p_frac [4] = '{8, 8, 8, 14};
  int    p_w    [4] = '{24, 24, 24, 16};
  int    p_den  [4] = '{1, 0, 1, 1};
  string p_nm   [4] = '{"a", "b", "c", "d"};

  // model: samples advanced since restart, drain flag and drain steps taken
  int m_n  [4];
  bit m_dr [4];
  int m_dc [4];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_state(input int i);
    int h;
    int r;
    h = p_half[i];
    if (m_n[i] < h) return 0;
    r = (m_n[i] - h) % (2 * h);
    return (r < h) ? 1 : 2;
  endfunction

  function automatic int exp_k(input int i);
    int h;
    h = p_half[i];
    if (exp_state(i) != 2) return 0;
    return (m_n[i] - h) % (2 * h) - h;
  endfunction

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic int exp_wr(input int i);
    real th;
    int  u;
    u = 1 << p_frac[i];
    if (exp_state(i) != 2) return u;
    th = PI * real'(exp_k(i)) / real'(p_half[i]);
    return rnd(real'(u) * $cos(th));
  endfunction

  function automatic int exp_wi(input int i);
    real th;
    int  u;
    u = 1 << p_frac[i];
    if (exp_state(i) != 2) return 0;
    th = PI * real'(exp_k(i)) / real'(p_half[i]);
    return -rnd(real'(u) * $sin(th));
  endfunction

  task automatic get_obs(input int i, output logic [31:0] st, output logic [31:0] k,
                         output logic [31:0] wr, output logic [31:0] wi,
                         output logic [31:0] dr, output logic [31:0] bz);
    case (i)
      0: begin st = 32'(if_a.state); k = 32'(if_a.k_out); wr = 32'(if_a.w_r); wi = 32'(if_a.w_i);
               dr = 32'(if_a.draining); bz = 32'(if_a.busy); end
      1: begin st = 32'(if_b.state); k = 32'(if_b.k_out); wr = 32'(if_b.w_r); wi = 32'(if_b.w_i);
               dr = 32'(if_b.draining); bz = 32'(if_b.busy); end
      2: begin st = 32'(if_c.state); k = 32'(if_c.k_out); wr = 32'(if_c.w_r); wi = 32'(if_c.w_i);
               dr = 32'(if_c.draining); bz = 32'(if_c.busy); end
      default: begin st = 32'(if_d.state); k = 32'(if_d.k_out); wr = 32'(if_d.w_r); wi = 32'(if_d.w_i);
               dr = 32'(if_d.draining); bz = 32'(if_d.busy); end
    endcase
  endtask

  task automatic check_all();
    logic [31:0] st, k, wr, wi, dr, bz, msk;
    int          es;
    for (int i = 0; i < 4; i++) begin
      get_obs(i, st, k, wr, wi, dr, bz);
      msk = (32'd1 << p_w[i]) - 32'd1;
      es  = exp_state(i);
      check({p_nm[i], ".state"}, st, 32'(es));
      check({p_nm[i], ".k_out"}, k, 32'(exp_k(i)));
      check({p_nm[i], ".w_r"}, wr, 32'(exp_wr(i)) & msk);
      check({p_nm[i], ".w_i"}, wi, 32'(exp_wi(i)) & msk);
      check({p_nm[i], ".draining"}, dr, 32'(m_dr[i]));
      check({p_nm[i], ".busy"}, bz, ((es != 0) || m_dr[i]) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_n[i]  = 0;
      m_dr[i] = 1'b0;
      m_dc[i] = 0;
    end
  endtask

  task automatic model_step(input bit iv, input bit clr);
    for (int i = 0; i < 4; i++) begin
      if (clr) begin
        m_n[i] = 0; m_dr[i] = 1'b0; m_dc[i] = 0;
      end else if (iv) begin
        m_n[i]++; m_dr[i] = 1'b0; m_dc[i] = 0;
      end else if ((p_den[i] != 0) && (m_dr[i] || (exp_state(i) != 0))) begin
        m_n[i]++;
        m_dc[i]++;
        m_dr[i] = 1'b1;
        if (m_dc[i] == p_half[i]) begin
          m_n[i] = 0; m_dr[i] = 1'b0; m_dc[i] = 0;
        end
      end
    end
  endtask

  // entered and left at posedge+1
  task automatic run_cycle(input bit iv, input bit clr);
    in_valid = iv;
    sync_clr = clr;
    check_all();
    @(posedge clk);
    #1;
    model_step(iv, clr);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    sync_clr = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_rst();
    in_valid = 1'b0;
    sync_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_step(1'b0, 1'b0);
  endtask

  initial begin
    int rate;
    @(posedge clk);
    #1;
    do_reset();

    // continuous stream from reset, with fixed spot values
    for (int s = 0; s < 660; s++) begin
      if (s == 31) check("a.s31.state", 32'(if_a.state), 32'd0);
      if (s == 32) begin
        check("a.s32.state", 32'(if_a.state), 32'd1);
        check("a.s32.wr", 32'(if_a.w_r), 32'd256);
      end
      if (s == 64) begin
        check("a.s64.state", 32'(if_a.state), 32'd2);
        check("a.s64.k", 32'(if_a.k_out), 32'd0);
        check("a.s64.wr", 32'(if_a.w_r), 32'd256);
        check("a.s64.wi", 32'(if_a.w_i), 32'd0);
      end
      if (s == 65) begin
        check("a.s65.k", 32'(if_a.k_out), 32'd1);
        check("a.s65.wr", 32'(if_a.w_r), 32'd255);
        check("a.s65.wi", 32'(if_a.w_i), 32'h00FFFFE7);
      end
      if (s == 72) begin
        check("a.s72.wr", 32'(if_a.w_r), 32'd181);
        check("a.s72.wi", 32'(if_a.w_i), 32'h00FFFF4B);
      end
      if (s == 80) begin
        check("a.s80.wr", 32'(if_a.w_r), 32'd0);
        check("a.s80.wi", 32'(if_a.w_i), 32'h00FFFF00);
      end
      if (s == 95) begin
        check("a.s95.wr", 32'(if_a.w_r), 32'h00FFFF01);
        check("a.s95.wi", 32'(if_a.w_i), 32'h00FFFFE7);
      end
      if (s == 96) check("a.s96.state", 32'(if_a.state), 32'd1);
      if (s == 10) begin
        check("c.k2.wr", 32'(if_c.w_r), 32'd0);
        check("c.k2.wi", 32'(if_c.w_i), 32'h00FFFF00);
      end
      if (s == 640) begin
        check("d.k128.k", 32'(if_d.k_out), 32'd128);
        check("d.k128.wi", 32'(if_d.w_i), 32'h0000C000);
      end
      run_cycle(1'b1, 1'b0);
    end

    // stall without drain: k holds at 6, then resumes at 7
    do_reset();
    for (int s = 0; s < 70; s++) run_cycle(1'b1, 1'b0);
    for (int s = 0; s < 5; s++) begin
      check("b.stall.k", 32'(if_b.k_out), 32'd6);
      run_cycle(1'b0, 1'b0);
    end
    check("b.resume.k0", 32'(if_b.k_out), 32'd6);
    run_cycle(1'b1, 1'b0);
    check("b.resume.k1", 32'(if_b.k_out), 32'd7);

    // full drain from the start of a BFLY half-frame
    do_reset();
    for (int s = 0; s < 96; s++) run_cycle(1'b1, 1'b0);
    for (int d = 0; d < 32; d++) begin
      check("a.drain.state", 32'(if_a.state), 32'd1);
      check("a.drain.flag", 32'(if_a.draining), (d > 0) ? 32'd1 : 32'd0);
      run_cycle(1'b0, 1'b0);
    end
    check("a.drained.state", 32'(if_a.state), 32'd0);
    check("a.drained.busy", 32'(if_a.busy), 32'd0);
    for (int d = 0; d < 4; d++) run_cycle(1'b0, 1'b0);

    // drain cancelled at drain cycle 10
    do_reset();
    for (int s = 0; s < 96; s++) run_cycle(1'b1, 1'b0);
    for (int d = 0; d < 10; d++) run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    check("a.cancel.flag", 32'(if_a.draining), 32'd0);
    for (int s = 0; s < 21; s++) run_cycle(1'b1, 1'b0);
    check("a.cancel.state", 32'(if_a.state), 32'd2);
    check("a.cancel.k", 32'(if_a.k_out), 32'd0);

    // sync_clr together with a sample
    do_reset();
    for (int s = 0; s < 80; s++) run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b1);
    check("a.clr.state", 32'(if_a.state), 32'd0);
    check("a.clr.wr", 32'(if_a.w_r), 32'd256);
    check("a.clr.wi", 32'(if_a.w_i), 32'd0);
    for (int s = 0; s < 32; s++) begin
      check("a.clr.fill", 32'(if_a.state), 32'd0);
      run_cycle(1'b1, 1'b0);
    end
    check("a.clr.bfly", 32'(if_a.state), 32'd1);

    // asynchronous reset mid-TWID and mid-drain
    do_reset();
    for (int s = 0; s < 70; s++) run_cycle(1'b1, 1'b0);
    pulse_rst();
    for (int s = 0; s < 96; s++) run_cycle(1'b1, 1'b0);
    for (int d = 0; d < 5; d++) run_cycle(1'b0, 1'b0);
    pulse_rst();

    // randomized bursts with occasional restarts
    do_reset();
    for (int blk = 0; blk < 20; blk++) begin
      case ($urandom_range(0, 3))
        0:       rate = 100;
        1:       rate = 90;
        2:       rate = 50;
        default: rate = 5;
      endcase
      for (int c = 0; c < 60; c++) begin
        run_cycle($urandom_range(0, 99) < rate, $urandom_range(0, 199) == 0);
      end
    end
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
